neg_accumulator: RTL and testbench
==================================

# neg_accumulator

Frame accumulator that sits directly downstream of the `twos_complement` negation stage. It consumes the 8-bit signed values that stage produces and sums a fixed number of them per frame. It then presents the signed frame sum and an overflow flag through a valid/ready handshake. Bit-serial-free, one sample per cycle, no combinational path from input to output.

## Interface
- `WIDTH`, 8: input sample width, two's complement.
- `ACC_WIDTH`, 12: accumulator and result width. Must satisfy `ACC_WIDTH >= WIDTH`.
- `COUNT`, 4: samples per frame. Must satisfy `COUNT >= 1`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous frame abort.
- `in_valid`  in  1  input sample valid.
- `in_ready`  out  1  block can accept a sample.
- `in_data`  in  `WIDTH`  signed sample, i.e. the negation stage's output.
- `out_valid`  out  1  frame result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_sum`  out  `ACC_WIDTH`  signed frame sum.
- `out_ovf`  out  1  sticky signed overflow for the frame.
- `busy`  out  1  high in ACCUM or HOLD.

## Operation
- Sample accept: `in_valid & in_ready` on a rising edge.
- Result accept: `out_valid & out_ready` on a rising edge.
- Sign extension: every input is sign-extended from `WIDTH` to `ACC_WIDTH` before it is added.
- Addition is done at `ACC_WIDTH`. Signed overflow is when both operands have the same sign and the result sign differs. Overflow sets the internal `ovf` flag, which stays set until the frame ends.
- FSM states: IDLE, ACCUM, HOLD.
- IDLE:
  - `in_ready=1`.
  - On accept: `acc <= sext(in_data)`, `cnt <= 1`, `ovf <= 0`.
  - Next state is HOLD if `COUNT==1`, otherwise ACCUM.
- ACCUM:
  - `in_ready=1`.
  - On accept: `acc <= acc + sext(in_data)`, `cnt <= cnt+1`.
  - When the accepted sample is number `COUNT`, the next state is HOLD.
  - Without an accept, state is held and there is no timeout.
- HOLD:
  - `in_ready=0`, `out_valid=1`, `out_sum=acc`, `out_ovf=ovf`.
  - On result accept, go to IDLE.
  - Outputs stay stable while `out_ready=0`.
- `clr`:
  - Has priority over all transitions.
  - Next state is IDLE; `acc`, `cnt` and `ovf` are cleared.
  - A sample or result presented in the same cycle is discarded, and no result is produced for the aborted frame.
- `in_ready` and `out_valid` are decoded from the state register only. They never depend on `in_valid` or `out_ready` combinationally.
- `in_data` is ignored whenever no accept happens.

## Timing
- Reset values (`rst_n=0`, asynchronous):
  - State is IDLE; `acc=0`, `cnt=0`, `ovf=0`.
  - `in_ready=1`, `out_valid=0`, `out_sum=0`, `out_ovf=0`, `busy=0`.
- Reset mid-frame or mid-HOLD drops the frame immediately. Outputs take their reset values without waiting for a clock edge.
- Latency: `out_valid` rises on the edge that accepts sample number `COUNT`, so it is visible the cycle after that accept.
- Throughput: one frame per `COUNT+1` cycles when `out_ready` is held high, because there is a minimum of one HOLD cycle.
- The first sample of the next frame is accepted no earlier than the cycle after the result accept.
- Outside HOLD, `out_sum` and `out_ovf` read as 0.

## Configuration
- Macro: `NEG_ACC_SAT_EN`.
- Defined:
  - On signed overflow, `acc` is clamped to +(2^(ACC_WIDTH-1))-1 for a positive overflow, or -(2^(ACC_WIDTH-1)) for a negative one.
  - Later additions start from the clamped value.
  - `ovf` is still set.
- Undefined: `acc` wraps modulo 2^ACC_WIDTH and `ovf` is set.

## Test plan
- Defaults, `out_ready=1`:
  - Input 0x01, 0x02, 0x7F, 0x80 on consecutive cycles → `out_valid` in cycle 5, `out_sum=0x002`, `out_ovf=0`.
  - Then IDLE and `in_ready=1` in cycle 6.
- Defaults, four samples of 0xFF → `out_sum=0xFFC` (-4), `out_ovf=0`.
- `ACC_WIDTH=8`, input 0x7F, 0x01, 0x00, 0x00:
  - Without the macro → `out_sum=0x80`, `out_ovf=1`.
  - With `NEG_ACC_SAT_EN` → `out_sum=0x7F`, `out_ovf=1`.
- Backpressure: hold `out_ready=0` for 3 cycles in HOLD while `in_valid=1` → `in_ready=0`, `out_sum` stable, no sample lost or absorbed; the result is accepted on the 4th cycle.
- `clr` pulse after 2 of 4 samples, then 0x05 ×4 → exactly one result, `out_sum=0x014`.
- Drop `rst_n` asynchronously in HOLD → `out_valid=0` with no clock edge needed, and the next frame sums from 0.

Source files
------------

// File: rtl/neg_accumulator.sv
// Frame accumulator for signed samples from the negation stage: sums COUNT samples per frame
// and presents the sum plus a sticky overflow flag. Optional saturation via NEG_ACC_SAT_EN.
module neg_accumulator #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 12,
  parameter int COUNT     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic                 out_ovf,
  output logic                 busy
);

  localparam int CNT_W = $clog2(COUNT + 1);
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                 state_reg, state_next;
  logic [ACC_WIDTH-1:0]   acc_reg, acc_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic                   ovf_reg, ovf_next;

  logic [ACC_WIDTH-1:0]   sext_data;
  logic [ACC_WIDTH-1:0]   sum_raw;
  logic [ACC_WIDTH-1:0]   add_res;
  logic                   add_ovf;
  logic                   in_fire;
  logic                   last_sample;

  // Sign extension: replicate the sample MSB into the upper accumulator bits.
  assign sext_data[WIDTH-1:0] = in_data;
  for (genvar gi = WIDTH; gi < ACC_WIDTH; gi++) begin : g_sext
    assign sext_data[gi] = in_data[WIDTH-1];
  end

  assign sum_raw = acc_reg + sext_data;
  assign add_ovf = (acc_reg[ACC_WIDTH-1] == sext_data[ACC_WIDTH-1]) &&
                   (sum_raw[ACC_WIDTH-1] != acc_reg[ACC_WIDTH-1]);

`ifdef NEG_ACC_SAT_EN
  // Clamp toward the sign of the operands when the sum wraps.
  assign add_res = add_ovf ? (acc_reg[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX) : sum_raw;
`else
  assign add_res = sum_raw;
`endif

  assign in_fire     = in_valid & in_ready;
  assign last_sample = (cnt_reg == CNT_W'(COUNT - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; clr overrides every transition.
  always_comb begin
    state_next = state_reg;
    if (clr) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (in_fire) state_next = (COUNT == 1) ? HOLD : ACCUM;
        ACCUM:   if (in_fire && last_sample) state_next = HOLD;
        HOLD:    if (out_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Outputs decoded from the state register only.
  always_comb begin
    in_ready  = (state_reg != HOLD);
    out_valid = (state_reg == HOLD);
    busy      = (state_reg != IDLE);
    out_sum   = out_valid ? acc_reg : '0;
    out_ovf   = out_valid & ovf_reg;
  end

  // Datapath next values
  always_comb begin
    acc_next = acc_reg;
    cnt_next = cnt_reg;
    ovf_next = ovf_reg;
    if (clr) begin
      acc_next = '0;
      cnt_next = '0;
      ovf_next = 1'b0;
    end else if (in_fire) begin
      if (state_reg == IDLE) begin
        acc_next = sext_data;
        cnt_next = CNT_W'(1);
        ovf_next = 1'b0;
      end else begin
        acc_next = add_res;
        cnt_next = cnt_reg + CNT_W'(1);
        ovf_next = ovf_reg | add_ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
      cnt_reg <= '0;
      ovf_reg <= 1'b0;
    end else begin
      acc_reg <= acc_next;
      cnt_reg <= cnt_next;
      ovf_reg <= ovf_next;
    end
  end

endmodule

// File: tb/tb_neg_accumulator.sv
// Directed bench for neg_accumulator: a 12-bit default instance and an 8-bit accumulator
// instance share the same stimulus; 8-bit expectations depend on NEG_ACC_SAT_EN.
module tb_neg_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, out_ovf, busy;
  logic [11:0] out_sum;
  logic        in_ready8, out_valid8, out_ovf8, busy8;
  logic [7:0]  out_sum8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  neg_accumulator dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf), .busy(busy)
  );

  neg_accumulator #(.ACC_WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready8), .in_data(in_data),
    .out_valid(out_valid8), .out_ready(out_ready),
    .out_sum(out_sum8), .out_ovf(out_ovf8), .busy(busy8)
  );

  typedef struct {
    logic [3:0][7:0] d;      // d[0] is the first sample
    logic [11:0]     sum12;
    logic            ovf12;
    logic [7:0]      sum8;   // 8-bit accumulator, wrapping
    logic            ovf8;
    logic [7:0]      sum8s;  // 8-bit accumulator, saturating
    logic            ovf8s;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send4(input logic [3:0][7:0] d);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = d[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = 8'hXX;
  endtask

  // Checks HOLD outputs on the 12-bit instance, then lets the result be taken.
  task automatic finish_frame(input string tag, input logic [11:0] exp_sum, input logic exp_ovf);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_in_ready_hold"}, 32'(in_ready), 32'd0);
    check({tag, "_sum"}, 32'(out_sum), 32'(exp_sum));
    check({tag, "_ovf"}, 32'(out_ovf), 32'(exp_ovf));
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_idle_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_idle_out_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    vecs[0] = '{d: 32'h807F0201, sum12: 12'h002, ovf12: 1'b0, sum8: 8'h02, ovf8: 1'b1, sum8s: 8'hFF, ovf8s: 1'b1};
    vecs[1] = '{d: 32'hFFFFFFFF, sum12: 12'hFFC, ovf12: 1'b0, sum8: 8'hFC, ovf8: 1'b0, sum8s: 8'hFC, ovf8s: 1'b0};
    vecs[2] = '{d: 32'h0000017F, sum12: 12'h080, ovf12: 1'b0, sum8: 8'h80, ovf8: 1'b1, sum8s: 8'h7F, ovf8s: 1'b1};
    vecs[3] = '{d: 32'h80808080, sum12: 12'hE00, ovf12: 1'b0, sum8: 8'h00, ovf8: 1'b1, sum8s: 8'h80, ovf8s: 1'b1};
    vecs[4] = '{d: 32'h7F7F7F7F, sum12: 12'h1FC, ovf12: 1'b0, sum8: 8'hFC, ovf8: 1'b1, sum8s: 8'h7F, ovf8s: 1'b1};
    vecs[5] = '{d: 32'hFB05F010, sum12: 12'h000, ovf12: 1'b0, sum8: 8'h00, ovf8: 1'b0, sum8s: 8'h00, ovf8s: 1'b0};

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven frames, out_ready held high
    for (int v = 0; v < 6; v++) begin
      logic [7:0] e8;
      logic       eo8;
`ifdef NEG_ACC_SAT_EN
      e8 = vecs[v].sum8s; eo8 = vecs[v].ovf8s;
`else
      e8 = vecs[v].sum8;  eo8 = vecs[v].ovf8;
`endif
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = vecs[v].d[0];
      @(posedge clk); #1;
      check($sformatf("v%0d_busy", v), 32'(busy), 32'd1);
      in_valid = 1'b1; in_data = vecs[v].d[1]; @(posedge clk); #1;
      in_valid = 1'b1; in_data = vecs[v].d[2]; @(posedge clk); #1;
      check($sformatf("v%0d_no_early_valid", v), 32'(out_valid), 32'd0);
      in_valid = 1'b1; in_data = vecs[v].d[3]; @(posedge clk); #1;
      in_valid = 1'b0;
      check($sformatf("v%0d_sum8", v), 32'(out_sum8), 32'(e8));
      check($sformatf("v%0d_ovf8", v), 32'(out_ovf8), 32'(eo8));
      $display("[TB] frame %0d: sum=0x%03h ovf=%0d sum8=0x%02h ovf8=%0d", v, out_sum, out_ovf, out_sum8, out_ovf8);
      finish_frame($sformatf("v%0d", v), vecs[v].sum12, vecs[v].ovf12);
    end

    // Backpressure: result held for 3 cycles while a sample is offered
    out_ready = 1'b0;
    send4(32'h03030303);
    in_valid = 1'b1; in_data = 8'h55;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
      check($sformatf("bp%0d_out_valid", c), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d_sum", c), 32'(out_sum), 32'h00C);
      @(posedge clk); #1;
    end
    $display("[TB] backpressure frame: sum=0x%03h", out_sum);
    in_valid = 1'b0;
    finish_frame("bp", 12'h00C, 1'b0);
    check("bp_busy_after", 32'(busy), 32'd0);
    send4(32'h01010101);
    finish_frame("bp_next", 12'h004, 1'b0);

    // clr after 2 of 4 samples; the abort-cycle sample is discarded
    in_valid = 1'b1; in_data = 8'h07; @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'h07; @(posedge clk); #1;
    clr = 1'b1; in_valid = 1'b1; in_data = 8'h30; @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_out_valid", 32'(out_valid), 32'd0);
    send4(32'h05050505);
    $display("[TB] post-clr frame: sum=0x%03h", out_sum);
    finish_frame("clr", 12'h014, 1'b0);

    // Asynchronous reset in HOLD
    out_ready = 1'b0;
    send4(32'h11223344);
    check("ar_hold_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_out_valid", 32'(out_valid), 32'd0);
    check("ar_out_sum", 32'(out_sum), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_in_ready", 32'(in_ready), 32'd1);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send4(32'h05050505);
    $display("[TB] post-reset frame: sum=0x%03h", out_sum);
    finish_frame("ar", 12'h014, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
